vector_floating_point_conversion_sequencer: RTL and testbench

Sequences one vector FP conversion instruction across its register group through the combinational `vector_floating_point_conversion_unit`. It strip-mines one VLEN-wide register per cycle: it reads vs2+i from the vector register file, drives the conversion unit, and writes vd+i. It sits between the issue stage (valid/ready request) and the vector register file (one read port, one write port).

---
 rtl/execution_vectors_pkg.sv | 18 +
 rtl/riscv_v_pkg.sv | 36 +++
 rtl/vector_floating_point_conversion_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vector_floating_point_conversion_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execution_vectors_pkg.sv
// Decoded control word shared by the vector FP conversion unit and its sequencer.
package execution_vectors_pkg;

    localparam int unsigned OPERATION_WIDTH = 4;
    localparam int unsigned SEW_WIDTH       = 2;
    localparam int unsigned RM_WIDTH        = 3;

    typedef struct packed {
        logic [OPERATION_WIDTH-1:0] operation;
        logic [SEW_WIDTH-1:0]       source_sew;
        logic [SEW_WIDTH-1:0]       destination_sew;
        logic [RM_WIDTH-1:0]        rounding_mode;
        logic                       widen;
        logic                       narrow;
        logic                       is_signed;
    } execution_vector_t;

endpackage

// File: rtl/riscv_v_pkg.sv
// Vector-extension constants, vlmul decoding and the conversion sequencer state encoding.
package riscv_v_pkg;

    localparam int unsigned VLEN             = 128;
    localparam int unsigned REG_ADDR_WIDTH   = 5;
    localparam int unsigned VLMUL_WIDTH      = 3;
    localparam int unsigned GROUP_SIZE_WIDTH = 4;

    localparam logic [VLMUL_WIDTH-1:0] VLMUL_1        = 3'b000;
    localparam logic [VLMUL_WIDTH-1:0] VLMUL_2        = 3'b001;
    localparam logic [VLMUL_WIDTH-1:0] VLMUL_4        = 3'b010;
    localparam logic [VLMUL_WIDTH-1:0] VLMUL_8        = 3'b011;
    localparam logic [VLMUL_WIDTH-1:0] VLMUL_RESERVED = 3'b100;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_READ  = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_ERR   = 2'd3
    } seq_state_t;

    // Fractional encodings still occupy one whole register.
    function automatic logic [GROUP_SIZE_WIDTH-1:0] vlmul_to_group_size(
        input logic [VLMUL_WIDTH-1:0] vlmul
    );
        logic [GROUP_SIZE_WIDTH-1:0] size;
        case (vlmul)
            VLMUL_2: size = GROUP_SIZE_WIDTH'(2);
            VLMUL_4: size = GROUP_SIZE_WIDTH'(4);
            VLMUL_8: size = GROUP_SIZE_WIDTH'(8);
            default: size = GROUP_SIZE_WIDTH'(1);
        endcase
        return size;
    endfunction

endpackage

// File: rtl/vector_floating_point_conversion_sequencer.sv
// Strip-mines one vector FP conversion across its register group: one register
// read per cycle, converted by the external combinational unit, written one cycle later.
module vector_floating_point_conversion_sequencer
    import execution_vectors_pkg::*;
#(
    parameter int unsigned VLEN           = riscv_v_pkg::VLEN,
    parameter int unsigned REG_ADDR_WIDTH = riscv_v_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      request_valid,
    output logic                      request_ready,
    input  execution_vector_t         request_execution_vector,
    input  logic [2:0]                request_vlmul,
    input  logic [REG_ADDR_WIDTH-1:0] request_vs2,
    input  logic [REG_ADDR_WIDTH-1:0] request_vd,
    input  logic                      flush,
    output logic                      rf_read_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_read_address,
    input  logic [VLEN-1:0]           rf_read_data,
    output execution_vector_t         cu_execution_vector,
    output logic [VLEN-1:0]           cu_vs2,
    input  logic [VLEN-1:0]           cu_vd,
    output logic                      rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_address,
    output logic [VLEN-1:0]           rf_write_data,
    output logic                      done,
    output logic                      illegal
);
    import riscv_v_pkg::seq_state_t;
    import riscv_v_pkg::SEQ_IDLE;
    import riscv_v_pkg::SEQ_READ;
    import riscv_v_pkg::SEQ_DRAIN;
    import riscv_v_pkg::SEQ_ERR;
    import riscv_v_pkg::VLMUL_RESERVED;
    import riscv_v_pkg::vlmul_to_group_size;

    localparam int unsigned INDEX_WIDTH = 3;
    localparam int unsigned GROUP_WIDTH = riscv_v_pkg::GROUP_SIZE_WIDTH;

    seq_state_t state;
    seq_state_t state_next;

    execution_vector_t         execution_vector_q;
    logic [REG_ADDR_WIDTH-1:0] vs2_base;
    logic [REG_ADDR_WIDTH-1:0] vd_base;
    logic [GROUP_WIDTH-1:0]    group_size;
    logic [INDEX_WIDTH-1:0]    read_index;
    logic [INDEX_WIDTH-1:0]    write_index;
    logic                      write_valid;
    logic                      done_q;

    logic                      accept;
    logic                      request_illegal;
    logic                      last_read;
    logic [GROUP_WIDTH-1:0]    request_group_size;
    logic [REG_ADDR_WIDTH-1:0] align_mask;

    // Aligned bases guarantee base+G-1 stays inside the register file.
    assign request_group_size = vlmul_to_group_size(request_vlmul);
    assign align_mask         = REG_ADDR_WIDTH'(request_group_size - GROUP_WIDTH'(1));
    assign request_illegal    = (request_vlmul == VLMUL_RESERVED)
                             || (|(request_vs2 & align_mask))
                             || (|(request_vd & align_mask));
    assign accept             = request_valid && (state == SEQ_IDLE);
    assign last_read          = (GROUP_WIDTH'(read_index) == (group_size - GROUP_WIDTH'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if ((state != SEQ_IDLE) && flush) begin
            state_next = SEQ_IDLE;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (accept) begin
                        state_next = request_illegal ? SEQ_ERR : SEQ_READ;
                    end
                end
                SEQ_READ: begin
                    if (last_read) begin
                        state_next = SEQ_DRAIN;
                    end
                end
                SEQ_DRAIN: state_next = SEQ_IDLE;
                SEQ_ERR:   state_next = SEQ_IDLE;
                default:   state_next = SEQ_IDLE;
            endcase
        end
    end

    // Strobes are gated by flush combinationally so the abort cycle touches nothing.
    always_comb begin
        request_ready       = 1'b0;
        rf_read_enable      = 1'b0;
        rf_read_address     = '0;
        rf_write_enable     = 1'b0;
        rf_write_address    = '0;
        rf_write_data       = '0;
        cu_vs2              = '0;
        cu_execution_vector = '0;
        done                = done_q;
        illegal             = 1'b0;

        request_ready  = (state == SEQ_IDLE);
        rf_read_enable = (state == SEQ_READ) && !flush;
        if (rf_read_enable) begin
            rf_read_address = vs2_base + REG_ADDR_WIDTH'(read_index);
        end
        rf_write_enable = write_valid && !flush;
        if (rf_write_enable) begin
            rf_write_address = vd_base + REG_ADDR_WIDTH'(write_index);
            rf_write_data    = cu_vd;
            cu_vs2           = rf_read_data;
        end
        if (state != SEQ_IDLE) begin
            cu_execution_vector = execution_vector_q;
        end
        illegal = (state == SEQ_ERR) && !flush;
    end

    // Request latch, strip-mine indices and the one-cycle read-to-write pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            execution_vector_q <= '0;
            vs2_base           <= '0;
            vd_base            <= '0;
            group_size         <= '0;
            read_index         <= '0;
            write_index        <= '0;
            write_valid        <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            write_valid <= rf_read_enable;
            done_q      <= (state == SEQ_DRAIN) && !flush;
            if (accept) begin
                execution_vector_q <= request_execution_vector;
                vs2_base           <= request_vs2;
                vd_base            <= request_vd;
                group_size         <= request_group_size;
                read_index         <= '0;
                write_index        <= '0;
            end else begin
                if (rf_read_enable) begin
                    read_index <= read_index + INDEX_WIDTH'(1);
                end
                if (rf_write_enable) begin
                    write_index <= write_index + INDEX_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_floating_point_conversion_sequencer.sv
// Scoreboarded bench for the conversion sequencer with behavioural register file and conversion unit.
module tb_vector_floating_point_conversion_sequencer;
    import execution_vectors_pkg::*;
    import riscv_v_pkg::*;

    typedef struct {
        logic [4:0] addr;
        int         cyc;
    } rd_t;

    typedef struct {
        logic [4:0]      addr;
        logic [VLEN-1:0] data;
        int              cyc;
    } wr_t;

    localparam execution_vector_t EV_VFADD_64 = '{operation: 4'h1, source_sew: 2'd3, destination_sew: 2'd3,
                                                  rounding_mode: 3'd0, widen: 1'b0, narrow: 1'b0, is_signed: 1'b1};
    localparam execution_vector_t EV_F2I_32   = '{operation: 4'h6, source_sew: 2'd2, destination_sew: 2'd2,
                                                  rounding_mode: 3'd1, widen: 1'b0, narrow: 1'b0, is_signed: 1'b0};
    localparam execution_vector_t EV_WIDEN    = '{operation: 4'h9, source_sew: 2'd1, destination_sew: 2'd2,
                                                  rounding_mode: 3'd4, widen: 1'b1, narrow: 1'b0, is_signed: 1'b1};

    logic              clock;
    logic              reset;
    logic              request_valid;
    logic              request_ready;
    execution_vector_t request_execution_vector;
    logic [2:0]        request_vlmul;
    logic [4:0]        request_vs2;
    logic [4:0]        request_vd;
    logic              flush;
    logic              rf_read_enable;
    logic [4:0]        rf_read_address;
    logic [VLEN-1:0]   rf_read_data;
    execution_vector_t cu_execution_vector;
    logic [VLEN-1:0]   cu_vs2;
    logic [VLEN-1:0]   cu_vd;
    logic              rf_write_enable;
    logic [4:0]        rf_write_address;
    logic [VLEN-1:0]   rf_write_data;
    logic              done;
    logic              illegal;

    logic [VLEN-1:0] rf_mem [32];
    rd_t exp_rd[$];
    wr_t exp_wr[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    vector_floating_point_conversion_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .request_valid            (request_valid),
        .request_ready            (request_ready),
        .request_execution_vector (request_execution_vector),
        .request_vlmul            (request_vlmul),
        .request_vs2              (request_vs2),
        .request_vd               (request_vd),
        .flush                    (flush),
        .rf_read_enable           (rf_read_enable),
        .rf_read_address          (rf_read_address),
        .rf_read_data             (rf_read_data),
        .cu_execution_vector      (cu_execution_vector),
        .cu_vs2                   (cu_vs2),
        .cu_vd                    (cu_vd),
        .rf_write_enable          (rf_write_enable),
        .rf_write_address         (rf_write_address),
        .rf_write_data            (rf_write_data),
        .done                     (done),
        .illegal                  (illegal)
    );

    // Stand-in conversion: rotate left by one, then mix in the control word.
    function automatic logic [VLEN-1:0] cu_model(input logic [VLEN-1:0] v, input execution_vector_t ev);
        logic [VLEN-1:0] mix;
        mix = '0;
        mix[$bits(execution_vector_t)-1:0] = ev;
        return {v[VLEN-2:0], v[VLEN-1]} ^ mix;
    endfunction

    assign cu_vd = cu_model(cu_vs2, cu_execution_vector);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (rf_read_enable) rf_read_data <= rf_mem[rf_read_address];
    end

    // Scoreboard: every strobe must match the next expected entry, including its cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (rf_read_enable) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read addr=%0d cycle=%0d", rf_read_address, cyc);
                end else begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    if (rf_read_address !== r.addr || cyc != r.cyc) begin
                        failures++;
                        $display("FAIL read got addr=%0d cycle=%0d expected addr=%0d cycle=%0d",
                                 rf_read_address, cyc, r.addr, r.cyc);
                    end
                end
            end
            if (rf_write_enable) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%0d cycle=%0d", rf_write_address, cyc);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    if (rf_write_address !== w.addr || rf_write_data !== w.data || cyc != w.cyc) begin
                        failures++;
                        $display("FAIL write got addr=%0d cycle=%0d data=%h expected addr=%0d cycle=%0d data=%h",
                                 rf_write_address, cyc, rf_write_data, w.addr, w.cyc, w.data);
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [4:0] vs2, input logic [4:0] vd, input execution_vector_t ev,
                                 input int acc, input int n_reads, input int n_writes);
        for (int i = 0; i < n_reads; i++) begin
            rd_t r;
            r.addr = vs2 + 5'(i);
            r.cyc  = acc + 1 + i;
            exp_rd.push_back(r);
        end
        for (int i = 0; i < n_writes; i++) begin
            wr_t w;
            logic [4:0] src;
            src    = vs2 + 5'(i);
            w.addr = vd + 5'(i);
            w.data = cu_model(rf_mem[src], ev);
            w.cyc  = acc + 2 + i;
            exp_wr.push_back(w);
        end
    endtask

    task automatic drive_request(input logic [2:0] vlmul, input logic [4:0] vs2, input logic [4:0] vd,
                                 input execution_vector_t ev);
        request_valid            = 1'b1;
        request_vlmul            = vlmul;
        request_vs2              = vs2;
        request_vd               = vd;
        request_execution_vector = ev;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++;
        if (request_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b expected=1", request_ready);
        end
        checks++;
        if ({rf_read_enable, rf_write_enable, done, illegal} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b expected=0000", {rf_read_enable, rf_write_enable, done, illegal});
        end
        checks++;
        if (rf_read_address !== 5'd0 || rf_write_address !== 5'd0 || rf_write_data !== '0 ||
            cu_vs2 !== '0 || cu_execution_vector !== '0) begin
            failures++;
            $display("FAIL reset_buses got ra=%0d wa=%0d expected zeros", rf_read_address, rf_write_address);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_group(input logic [2:0] vlmul, input int g, input logic [4:0] vs2,
                              input logic [4:0] vd, input execution_vector_t ev, input string name);
        int c;
        @(posedge clock);
        #1;
        c = cyc;
        drive_request(vlmul, vs2, vd, ev);
        push_expected(vs2, vd, ev, c, g, g);
        @(negedge clock);
        checks++;
        if (request_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept_ready got=%b expected=1", name, request_ready);
        end
        for (int k = 1; k <= g + 2; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) request_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (done !== (k == g + 2) || request_ready !== (k == g + 2) || illegal !== 1'b0) begin
                failures++;
                $display("FAIL %s_done cycle=%0d got done=%b ready=%b illegal=%b expected done=%b",
                         name, k, done, request_ready, illegal, (k == g + 2));
            end
        end
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL %s_missing got rd_left=%0d wr_left=%0d expected 0", name, exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_illegal(input logic [2:0] vlmul, input logic [4:0] vs2, input logic [4:0] vd,
                                input string name);
        @(posedge clock);
        #1;
        drive_request(vlmul, vs2, vd, EV_F2I_32);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) request_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (illegal !== (k == 1) || request_ready !== (k != 1) || done !== 1'b0) begin
                failures++;
                $display("FAIL %s cycle=%0d got illegal=%b ready=%b done=%b expected illegal=%b ready=%b done=0",
                         name, k, illegal, request_ready, done, (k == 1), (k != 1));
            end
        end
    endtask

    task automatic test_flush;
        int c;
        @(posedge clock);
        #1;
        c = cyc;
        drive_request(VLMUL_8, 5'd8, 5'd16, EV_WIDEN);
        push_expected(5'd8, 5'd16, EV_WIDEN, c, 3, 2);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) request_valid = 1'b0;
            if (k == 4) flush = 1'b1;
            if (k == 5) flush = 1'b0;
            @(negedge clock);
            if (k == 4) begin
                checks++;
                if (rf_read_enable !== 1'b0 || rf_write_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_strobes got rd=%b wr=%b expected 0 0", rf_read_enable, rf_write_enable);
                end
            end
            if (k >= 4) begin
                checks++;
                if (done !== 1'b0 || illegal !== 1'b0 || (k >= 5 && request_ready !== 1'b1)) begin
                    failures++;
                    $display("FAIL flush_after cycle=%0d got done=%b illegal=%b ready=%b", k, done, illegal, request_ready);
                end
            end
        end
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL flush_missing got rd_left=%0d wr_left=%0d expected 0", exp_rd.size(), exp_wr.size());
        end
        // Flush coinciding with a request in IDLE must not disturb the acceptance.
        @(posedge clock);
        #1;
        c = cyc;
        drive_request(VLMUL_1, 5'd5, 5'd7, EV_F2I_32);
        flush = 1'b1;
        push_expected(5'd5, 5'd7, EV_F2I_32, c, 1, 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) begin
                request_valid = 1'b0;
                flush         = 1'b0;
            end
            @(negedge clock);
            checks++;
            if (done !== (k == 3)) begin
                failures++;
                $display("FAIL flush_next_done cycle=%0d got=%b expected=%b", k, done, (k == 3));
            end
        end
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL flush_next_missing got rd_left=%0d wr_left=%0d expected 0", exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_back_to_back;
        int c;
        @(posedge clock);
        #1;
        c = cyc;
        drive_request(VLMUL_2, 5'd2, 5'd4, EV_VFADD_64);
        push_expected(5'd2, 5'd4, EV_VFADD_64, c, 2, 2);
        push_expected(5'd10, 5'd12, EV_WIDEN, c + 4, 2, 2);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) drive_request(VLMUL_2, 5'd10, 5'd12, EV_WIDEN);
            if (k == 5) request_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (done !== (k == 4 || k == 8) || request_ready !== (k == 4 || k == 8)) begin
                failures++;
                $display("FAIL b2b cycle=%0d got done=%b ready=%b expected=%b", k, done, request_ready, (k == 4 || k == 8));
            end
        end
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL b2b_missing got rd_left=%0d wr_left=%0d expected 0", exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset_mid;
        int c;
        @(posedge clock);
        #1;
        c = cyc;
        drive_request(VLMUL_8, 5'd0, 5'd24, EV_F2I_32);
        push_expected(5'd0, 5'd24, EV_F2I_32, c, 2, 1);
        @(posedge clock);
        #1 request_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (request_ready !== 1'b1 || rf_read_enable !== 1'b0 || rf_write_enable !== 1'b0 ||
            done !== 1'b0 || illegal !== 1'b0 || cu_execution_vector !== '0 || rf_read_address !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid got ready=%b rd=%b wr=%b done=%b ra=%0d expected 1 0 0 0 0",
                     request_ready, rf_read_enable, rf_write_enable, done, rf_read_address);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0 || request_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after got rd_left=%0d wr_left=%0d ready=%b expected 0 0 1",
                     exp_rd.size(), exp_wr.size(), request_ready);
        end
    endtask

    initial begin
        reset                    = 1'b1;
        request_valid            = 1'b0;
        request_execution_vector = '0;
        request_vlmul            = 3'd0;
        request_vs2              = 5'd0;
        request_vd               = 5'd0;
        flush                    = 1'b0;
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom, $urandom, $urandom};

        test_reset();
        test_group(VLMUL_1, 1, 5'd4, 5'd8, EV_VFADD_64, "single");
        test_group(VLMUL_8, 8, 5'd8, 5'd16, EV_F2I_32, "group8");
        test_group(VLMUL_4, 4, 5'd12, 5'd20, EV_WIDEN, "group4");
        test_group(3'b110, 1, 5'd3, 5'd9, EV_F2I_32, "fractional");
        test_illegal(VLMUL_4, 5'd6, 5'd8, "misaligned");
        test_illegal(VLMUL_RESERVED, 5'd0, 5'd0, "reserved");
        test_illegal(VLMUL_2, 5'd2, 5'd5, "misaligned_vd");
        test_flush();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
